// File: rtl/axi_mst_rd_ctrl_pkg.sv
// Shared AXI4 widths and encodings for the read initiator.
package axi_mst_rd_ctrl_pkg;

  localparam int unsigned AxiAddrWidth   = 32;
  localparam int unsigned AxiDataWidth   = 32;
  localparam int unsigned AxiLenWidth    = 8;
  localparam int unsigned AxiIdWidth     = 4;
  localparam int unsigned AxiRespWidth   = 2;
  localparam int unsigned AxiSizeWidth   = 3;
  localparam int unsigned AxiBurstWidth  = 2;
  localparam int unsigned AxiCacheWidth  = 4;
  localparam int unsigned AxiProtWidth   = 3;
  localparam int unsigned AxiQosWidth    = 4;
  localparam int unsigned AxiRegionWidth = 4;

  // Burst types
  localparam logic [AxiBurstWidth-1:0] AxiBurstFixed = 2'b00;
  localparam logic [AxiBurstWidth-1:0] AxiBurstIncr  = 2'b01;
  localparam logic [AxiBurstWidth-1:0] AxiBurstWrap  = 2'b10;

  // Response codes
  localparam logic [AxiRespWidth-1:0] AxiRespOkay   = 2'b00;
  localparam logic [AxiRespWidth-1:0] AxiRespExOkay = 2'b01;
  localparam logic [AxiRespWidth-1:0] AxiRespSlvErr = 2'b10;
  localparam logic [AxiRespWidth-1:0] AxiRespDecErr = 2'b11;

endpackage

// File: rtl/axi_mst_rd_ctrl.sv
// AXI4 read initiator: one user request becomes one INCR AR burst; R beats are passed
// straight through to the user stream. Single outstanding transaction.
module axi_mst_rd_ctrl
  import axi_mst_rd_ctrl_pkg::*;
#(
  parameter int unsigned ARID       = 0,
  parameter int unsigned ADDR_ALIGN = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  // User request
  input  logic                      rd_req_valid,
  output logic                      rd_req_ready,
  input  logic [AxiAddrWidth-1:0]   rd_req_addr,
  input  logic [AxiLenWidth-1:0]    rd_req_len,
  // User data stream
  output logic                      rd_data_valid,
  input  logic                      rd_data_ready,
  output logic [AxiDataWidth-1:0]   rd_data,
  output logic [AxiRespWidth-1:0]   rd_data_resp,
  output logic                      rd_data_last,
  output logic                      rd_done,
  output logic                      rd_err,
  // AR channel
  output logic                      axi_mst_arvalid,
  input  logic                      axi_mst_arready,
  output logic [AxiIdWidth-1:0]     axi_mst_arid,
  output logic [AxiAddrWidth-1:0]   axi_mst_araddr,
  output logic [AxiLenWidth-1:0]    axi_mst_arlen,
  output logic [AxiSizeWidth-1:0]   axi_mst_arsize,
  output logic [AxiBurstWidth-1:0]  axi_mst_arburst,
  output logic                      axi_mst_arlock,
  output logic [AxiCacheWidth-1:0]  axi_mst_arcache,
  output logic [AxiProtWidth-1:0]   axi_mst_arprot,
  output logic [AxiQosWidth-1:0]    axi_mst_arqos,
  output logic [AxiRegionWidth-1:0] axi_mst_arregion,
  // R channel
  input  logic                      axi_mst_rvalid,
  output logic                      axi_mst_rready,
  input  logic [AxiIdWidth-1:0]     axi_mst_rid,
  input  logic [AxiDataWidth-1:0]   axi_mst_rdata,
  input  logic [AxiRespWidth-1:0]   axi_mst_rresp,
  input  logic                      axi_mst_rlast
);

  typedef enum logic [1:0] {StIdle, StAr, StRd, StDone} state_e;

  localparam logic [AxiAddrWidth-1:0] AlignMask =
    AxiAddrWidth'((64'd1 << ADDR_ALIGN) - 64'd1);
  localparam logic [AxiIdWidth-1:0] ArId = AxiIdWidth'(ARID);

  state_e                  state_q, state_d;
  logic [AxiAddrWidth-1:0] addr_q, addr_d;
  logic [AxiLenWidth-1:0]  len_q, len_d;
  logic [AxiLenWidth-1:0]  beat_cnt_q, beat_cnt_d;
  logic                    err_q, err_d;

  logic in_rd;
  logic beat_fire;
  logic beat_err;
  logic misaligned;

  // Output decode and R pass-through; AR payload comes only from registers
  always_comb begin
    in_rd            = (state_q == StRd);
    rd_req_ready     = (state_q == StIdle);
    rd_done          = (state_q == StDone);
    rd_err           = err_q;

    axi_mst_arvalid  = (state_q == StAr);
    axi_mst_arid     = ArId;
    axi_mst_araddr   = addr_q;
    axi_mst_arlen    = len_q;
    axi_mst_arsize   = AxiSizeWidth'(ADDR_ALIGN);
    axi_mst_arburst  = AxiBurstIncr;
    axi_mst_arlock   = 1'b0;
    axi_mst_arcache  = '0;
    axi_mst_arprot   = '0;
    axi_mst_arqos    = '0;
    axi_mst_arregion = '0;

    // No skid buffer: user backpressure goes straight to the slave
    rd_data_valid    = in_rd & axi_mst_rvalid;
    axi_mst_rready   = in_rd & rd_data_ready;
    rd_data          = axi_mst_rdata;
    rd_data_resp     = axi_mst_rresp;
    // Last is derived from our own count, never from the slave's rlast
    rd_data_last     = in_rd & (beat_cnt_q == len_q);

    beat_fire        = in_rd & axi_mst_rvalid & rd_data_ready;
    beat_err         = (axi_mst_rresp != AxiRespOkay) | (axi_mst_rid != ArId) |
                       (axi_mst_rlast != rd_data_last);
    misaligned       = |(rd_req_addr & AlignMask);
  end

  // Next-state logic for FSM, latched request, beat counter and sticky error
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    case (state_q)
      StIdle: begin
        if (rd_req_valid) begin
          addr_d     = rd_req_addr;
          len_d      = rd_req_len;
          beat_cnt_d = '0;
          // Misaligned requests are still issued unmodified, just flagged
          err_d      = misaligned;
          state_d    = StAr;
        end
      end
      StAr: begin
        if (axi_mst_arready) state_d = StRd;
      end
      StRd: begin
        if (beat_fire) begin
          beat_cnt_d = beat_cnt_q + AxiLenWidth'(1);
          if (beat_err) err_d = 1'b1;
          if (rd_data_last) state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_mst_rd_ctrl.sv
// Bench for axi_mst_rd_ctrl: a task plays user and AXI slave, pushing expected AR,
// beats and error flags into queues; a negedge monitor pops and compares.
module tb_axi_mst_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_req_valid, rd_req_ready;
  logic [31:0] rd_req_addr;
  logic [7:0]  rd_req_len;
  logic        rd_data_valid, rd_data_ready;
  logic [31:0] rd_data;
  logic [1:0]  rd_data_resp;
  logic        rd_data_last, rd_done, rd_err;
  logic        arvalid, arready, arlock;
  logic [3:0]  arid, arcache, arqos, arregion;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst;
  logic        rvalid, rready, rlast;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  axi_mst_rd_ctrl dut (
    .clk(clk), .rst(rst),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
    .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready),
    .rd_data(rd_data), .rd_data_resp(rd_data_resp), .rd_data_last(rd_data_last),
    .rd_done(rd_done), .rd_err(rd_err),
    .axi_mst_arvalid(arvalid), .axi_mst_arready(arready), .axi_mst_arid(arid),
    .axi_mst_araddr(araddr), .axi_mst_arlen(arlen), .axi_mst_arsize(arsize),
    .axi_mst_arburst(arburst), .axi_mst_arlock(arlock), .axi_mst_arcache(arcache),
    .axi_mst_arprot(arprot), .axi_mst_arqos(arqos), .axi_mst_arregion(arregion),
    .axi_mst_rvalid(rvalid), .axi_mst_rready(rready), .axi_mst_rid(rid),
    .axi_mst_rdata(rdata), .axi_mst_rresp(rresp), .axi_mst_rlast(rlast)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] addr; logic [7:0] len;} ar_t;
  typedef struct packed {logic [31:0] data; logic [1:0] resp; logic last;} beat_t;

  ar_t   ar_q[$];
  beat_t beat_q[$];
  bit    err_q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int pat[4] = '{1, 0, 0, 1};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor state: transaction phase as seen from the handshakes
  int          ph = 0;  // 0 idle, 1 awaiting AR handshake, 2 collecting beats
  bit          done_exp = 0, arv_exp = 0, ar_stall = 0, err_last = 0;
  logic [64:0] ar_prev;
  logic [64:0] ar_pay;
  assign ar_pay = {arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
                   arregion};

  always @(negedge clk) begin
    int    nxt_ph;
    bit    in_done, nxt_done;
    ar_t   a;
    beat_t b;
    if (rst) begin
      ar_q.delete(); beat_q.delete(); err_q.delete();
      ph = 0; done_exp = 0; arv_exp = 0; ar_stall = 0; err_last = 0;
    end else begin
      in_done  = done_exp;
      nxt_ph   = ph;
      nxt_done = 0;
      chk("rd_done", rd_done, in_done);
      if (in_done) begin
        if (err_q.size() == 0) chk("err_queue_empty", 0, 1);
        else begin
          err_last = err_q.pop_front();
          chk("rd_err_at_done", rd_err, err_last);
        end
      end
      chk("rd_req_ready", rd_req_ready, (ph == 0 && !in_done));
      if (ph == 0 && !in_done) chk("rd_err_idle", rd_err, err_last);
      if (arv_exp) chk("ar_latency", arvalid, 1);
      arv_exp = 0;
      if (ph == 1) begin
        if (ar_stall) chk("ar_stable", (arvalid && ar_pay == ar_prev), 1);
        if (arvalid && arready) begin
          ar_stall = 0;
          nxt_ph   = 2;
          if (ar_q.size() == 0) chk("ar_queue_empty", 0, 1);
          else begin
            a = ar_q.pop_front();
            chk("araddr", araddr, a.addr);
            chk("arlen", arlen, a.len);
            chk("arsize", arsize, 2);
            chk("arburst", arburst, 1);
            chk("arid", arid, 0);
            chk("ar_misc", {arlock, arcache, arprot, arqos, arregion}, 0);
          end
        end else begin
          ar_stall = arvalid;
          ar_prev  = ar_pay;
        end
      end else chk("arvalid_off", arvalid, 0);
      if (ph == 2) begin
        chk("rready_mirror", rready, rd_data_ready);
        chk("rvalid_mirror", rd_data_valid, rvalid);
        if (rd_data_valid && rd_data_ready) begin
          if (beat_q.size() == 0) chk("beat_queue_empty", 0, 1);
          else begin
            b = beat_q.pop_front();
            chk("rd_data", rd_data, b.data);
            chk("rd_data_resp", rd_data_resp, b.resp);
            chk("rd_data_last", rd_data_last, b.last);
            if (b.last) begin nxt_ph = 0; nxt_done = 1; end
          end
        end
      end else begin
        chk("rready_off", rready, 0);
        chk("rd_data_valid_off", rd_data_valid, 0);
      end
      if (rd_req_valid && rd_req_ready) begin nxt_ph = 1; arv_exp = 1; end
      ph       = nxt_ph;
      done_exp = nxt_done;
    end
  end

  // One transaction: user request, slave AR with delay, slave R beats, user backpressure.
  task automatic do_txn(input logic [31:0] addr, input int len, input int ar_dly,
                        input int rv_pct, input int rdy_mode, input int rlast_at,
                        input int bad_resp, input int bad_id, input bit early_r,
                        input bit seq_data, input int rst_after);
    logic [31:0] dat[$];
    bit          exp_err, pend;
    int          i, k, c, g;
    ar_t         a;
    beat_t       b;
    a.addr = addr;
    a.len  = 8'(len);
    ar_q.push_back(a);
    exp_err = (addr[1:0] != 2'b00) || (rlast_at != len) ||
              (bad_resp >= 0 && bad_resp <= len) || (bad_id >= 0 && bad_id <= len);
    for (int j = 0; j <= len; j++) begin
      dat.push_back(seq_data ? 32'hA0 + 32'(j) : $urandom);
      b.data = dat[j];
      b.resp = (j == bad_resp) ? 2'b10 : 2'b00;
      b.last = (j == len);
      beat_q.push_back(b);
    end
    err_q.push_back(exp_err);

    @(posedge clk); #1;
    rd_req_valid = 1; rd_req_addr = addr; rd_req_len = 8'(len);
    g = 0;
    @(negedge clk);
    while (!rd_req_ready) begin
      g++;
      if (g > 50) begin chk("req_timeout", 0, 1); rd_req_valid = 0; return; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    rd_req_valid = 0;
    if (early_r) begin rvalid = 1; rdata = 32'hDEAD_BEEF; rlast = 1; end
    k = 0;
    forever begin
      arready = (k >= ar_dly);
      @(negedge clk);
      if (arvalid && arready) break;
      k++;
      if (k > 50) begin chk("ar_timeout", 0, 1); arready = 0; return; end
      @(posedge clk); #1;
    end

    i = 0; c = 0; g = 0; pend = 0;
    while (i <= len) begin
      @(posedge clk); #1;
      arready = 0;
      if (i == rst_after) begin
        rvalid = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("post_rst_req_ready", rd_req_ready, 1);
        chk("post_rst_arvalid", arvalid, 0);
        chk("post_rst_rready", rready, 0);
        chk("post_rst_rd_err", rd_err, 0);
        chk("post_rst_rd_done", rd_done, 0);
        return;
      end
      if (!pend) pend = ($urandom_range(1, 100) <= rv_pct);
      rvalid = pend;
      rdata  = dat[i];
      rresp  = (i == bad_resp) ? 2'b10 : 2'b00;
      rid    = (i == bad_id) ? 4'h1 : 4'h0;
      rlast  = (i == rlast_at);
      case (rdy_mode)
        0:       rd_data_ready = 1'b1;
        1:       rd_data_ready = 1'($urandom_range(0, 1));
        default: rd_data_ready = (c < 4) ? (pat[c] != 0) : 1'b1;
      endcase
      c++;
      @(negedge clk);
      if (rvalid && rready) begin i++; pend = 0; end
      g++;
      if (g > 3000) begin chk("r_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    rvalid = 0; rlast = 0; rd_data_ready = 1;
  endtask

  initial begin
    logic [31:0] ad;
    int          ln, rla, bre, bid;
    rd_req_valid = 0; rd_req_addr = '0; rd_req_len = '0; rd_data_ready = 1;
    arready = 0; rvalid = 0; rid = '0; rdata = '0; rresp = '0; rlast = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_req_ready", rd_req_ready, 1);
    chk("reset_arvalid", arvalid, 0);
    chk("reset_rready", rready, 0);
    chk("reset_rd_done", rd_done, 0);
    chk("reset_rd_err", rd_err, 0);

    // addr, len, ar_dly, rv%, rdy_mode, rlast_at, bad_resp, bad_id, early, seq, rst_after
    do_txn(32'h100, 3, 0, 100, 0, 3, -1, -1, 0, 0, -1);   // basic 4-beat burst
    do_txn(32'h2000, 2, 5, 100, 0, 2, -1, -1, 1, 0, -1);  // AR stall, early rvalid
    do_txn(32'h40, 0, 0, 100, 0, 0, 0, -1, 0, 0, -1);     // len 0, SLVERR
    repeat (3) @(posedge clk);                            // error held in idle
    do_txn(32'h80, 1, 1, 100, 0, 1, -1, -1, 0, 0, -1);    // clean request clears error
    do_txn(32'h200, 3, 0, 100, 0, 1, -1, -1, 0, 0, -1);   // early rlast on beat 2
    do_txn(32'h300, 3, 0, 100, 2, 3, -1, -1, 0, 1, -1);   // ready 1,0,0,1, data A0..A3
    do_txn(32'h400, 2, 0, 100, 0, 2, -1, 1, 0, 0, -1);    // bad rid
    do_txn(32'h502, 1, 0, 100, 0, 1, -1, -1, 0, 0, -1);   // misaligned address
    do_txn(32'h1000, 255, 2, 100, 0, 255, -1, -1, 0, 0, -1); // max length
    do_txn(32'h600, 7, 0, 100, 0, 7, 0, -1, 0, 0, 1);     // reset after first beat
    do_txn(32'h700, 2, 0, 100, 0, 2, -1, -1, 0, 0, -1);   // recovery after reset

    for (int t = 0; t < 30; t++) begin
      ad = $urandom & 32'hFFFF_FFF0;
      if ($urandom_range(0, 7) == 0) ad = ad | 32'($urandom_range(1, 3));
      ln  = $urandom_range(0, 15);
      rla = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : ln;
      bre = ($urandom_range(0, 9) == 0) ? $urandom_range(0, ln) : -1;
      bid = ($urandom_range(0, 9) == 0) ? $urandom_range(0, ln) : -1;
      do_txn(ad, ln, $urandom_range(0, 3), $urandom_range(30, 100), $urandom_range(0, 1),
             rla, bre, bid, 1'($urandom_range(0, 1)), 0, -1);
    end

    repeat (5) @(negedge clk);
    chk("beats_left", beat_q.size(), 0);
    chk("ar_left", ar_q.size(), 0);
    chk("err_left", err_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
